// File: rtl/pipes_updater_pkg.sv
// Shared pipe obstacle types and geometry used by the updater,
// the renderer and the collision logic.
package pipes_updater_pkg;

    localparam int SCREEN_WIDTH_D = 640;
    localparam int PIPE_WIDTH_D   = 52;

    typedef struct packed {
        logic signed [10:0] x;
        logic        [8:0]  gap_y;
    } pipe_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ITER,
        S_SPAWN
    } upd_state_e;

endpackage

// File: rtl/pipes_updater_if.sv
// Iterate/insert port of the pipe list; the updater is the master.
import pipes_updater_pkg::*;

interface pipes_updater_if;

    logic [4:0] count;
    logic       iter_start;
    logic       iter_done;
    pipe_t      iter_out;
    pipe_t      iter_in;
    logic       iter_remove;
    logic       insert_en;
    pipe_t      insert_data;

    modport master (
        input  count,
        input  iter_done,
        input  iter_out,
        output iter_start,
        output iter_in,
        output iter_remove,
        output insert_en,
        output insert_data
    );

    modport slave (
        output count,
        output iter_done,
        output iter_out,
        input  iter_start,
        input  iter_in,
        input  iter_remove,
        input  insert_en,
        input  insert_data
    );

endinterface

// File: rtl/pipes_updater_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise gap height.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb  = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];
    assign value = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (ce && step) begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

endmodule

// File: rtl/pipes_updater.sv
// Per-frame pipe scroller/spawner: one iterate pass over the pipe list,
// then an optional append of a freshly spawned pipe.
import pipes_updater_pkg::*;

module pipes_updater #(
    parameter int SCREEN_WIDTH   = SCREEN_WIDTH_D,
    parameter int PIPE_WIDTH     = PIPE_WIDTH_D,
    parameter int SPAWN_INTERVAL = 200,
    parameter int MAX_PIPES      = 16,
    parameter int GAP_MIN        = 64,
    parameter int GAP_RANGE_LOG2 = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   frame_start,
    input  logic [3:0]             speed,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_missed,
    pipes_updater_if.master        lst
);

    upd_state_e r_state;
    upd_state_e w_next;

    logic [9:0]  r_dist;
    logic [3:0]  r_spd_q;
    logic [15:0] w_lfsr;
    logic [10:0] w_dist_sum;
    logic        w_accept;
    logic        w_spawn;
    logic        w_in_step;

    logic signed [11:0] w_nx;
    logic signed [11:0] w_edge;

    assign w_accept   = (r_state == S_IDLE) && frame_start;
    assign w_dist_sum = {1'b0, r_dist} + 11'(speed);
    assign w_spawn    = (r_state == S_SPAWN)
                      && (32'(r_dist) >= SPAWN_INTERVAL)
                      && (32'(lst.count) < MAX_PIPES);
    assign w_in_step  = (r_state == S_ITER) && !lst.iter_done;

    // 12-bit signed step so x near -1024 minus speed cannot wrap
    assign w_nx   = $signed({lst.iter_out.x[10], lst.iter_out.x})
                  - $signed({8'b0, r_spd_q});
    assign w_edge = w_nx + 12'(PIPE_WIDTH);

    lfsr16 #(
        .SEED (16'hACE1)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .step  (w_spawn),
        .value (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dist  <= '0;
            r_spd_q <= '0;
        end else if (ce) begin
            if (w_accept) begin
                r_spd_q <= speed;
                r_dist  <= w_dist_sum[10] ? 10'h3FF : w_dist_sum[9:0];
            end else if (w_spawn) begin
                r_dist  <= r_dist - 10'(SPAWN_INTERVAL);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (frame_start) w_next = S_START;
            S_START: w_next = S_ITER;
            S_ITER:  if (lst.iter_done) w_next = S_SPAWN;
            S_SPAWN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy             = (r_state != S_IDLE);
        done             = (r_state == S_SPAWN);
        frame_missed     = frame_start && (r_state != S_IDLE);
        lst.iter_start   = (r_state == S_START);
        lst.iter_remove  = 1'b0;
        lst.iter_in      = '0;
        lst.insert_en    = w_spawn;
        lst.insert_data  = '0;
        if (w_in_step) begin
            lst.iter_remove   = w_edge[11] || (w_edge == 12'sd0);
            lst.iter_in.x     = w_nx[10:0];
            lst.iter_in.gap_y = lst.iter_out.gap_y;
        end
        if (w_spawn) begin
            lst.insert_data.x     = 11'(SCREEN_WIDTH);
            lst.insert_data.gap_y = 9'(GAP_MIN)
                                  + 9'(w_lfsr[GAP_RANGE_LOG2-1:0]);
        end
    end

endmodule

// File: tb/tb_pipes_updater.sv
// Directed bench for pipes_updater with a hand-driven pipe list.
import pipes_updater_pkg::*;

module tb_pipes_updater;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       frame_start;
    logic [3:0] speed;
    logic       busy;
    logic       done;
    logic       frame_missed;

    pipes_updater_if lif ();

    pipes_updater dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .frame_start  (frame_start),
        .speed        (speed),
        .busy         (busy),
        .done         (done),
        .frame_missed (frame_missed),
        .lst          (lif.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_t ex_in [0:3];
    pipe_t wb    [0:3];
    logic  rm    [0:3];
    int    start_at;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Pulses frame_start and plays an n-element list; offsets are from T.
    task automatic run_pass(input logic [3:0] spd, input int n,
                            output int done_at, output bit ins,
                            output pipe_t ins_d);
        done_at  = -1;
        start_at = -1;
        ins      = 1'b0;
        ins_d    = '0;
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        speed       = spd;
        for (int c = 0; c < n + 8 && done_at < 0; c++) begin
            if (c == 1) frame_start = 1'b0;
            if (c >= 2 && c - 2 < n) begin
                lif.iter_done = 1'b0;
                lif.iter_out  = ex_in[c-2];
            end else begin
                lif.iter_done = 1'b1;
            end
            @(negedge clk);
            if (c >= 2 && c - 2 < n) begin
                wb[c-2] = lif.iter_in;
                rm[c-2] = lif.iter_remove;
            end
            if (lif.iter_start && start_at < 0) start_at = c;
            if (done) done_at = c;
            if (lif.insert_en) begin
                ins   = 1'b1;
                ins_d = lif.insert_data;
            end
            @(posedge clk);
            #1;
        end
        frame_start   = 1'b0;
        lif.iter_done = 1'b1;
    endtask

    initial begin
        int    d_at;
        bit    ins;
        pipe_t ins_d;
        int    spawns;
        int    spawn_frame;
        int    bad_done;
        pipe_t sp_d;

        rst           = 1'b1;
        ce            = 1'b1;
        frame_start   = 1'b0;
        speed         = '0;
        lif.count     = '0;
        lif.iter_done = 1'b1;
        lif.iter_out  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_istart", 32'(lif.iter_start), 0);
        chk("rst_ins", 32'(lif.insert_en), 0);
        chk("rst_rm", 32'(lif.iter_remove), 0);
        chk("rst_iin", 32'(lif.iter_in), 0);
        chk("rst_idata", 32'(lif.insert_data), 0);
        chk("rst_dist", 32'(dut.r_dist), 0);
        chk("rst_lfsr", 32'(dut.w_lfsr), 32'hACE1);

        // empty list, speed 4
        run_pass(4'd4, 0, d_at, ins, ins_d);
        chk("e_start_at", 32'(start_at), 1);
        chk("e_done_at", 32'(d_at), 3);
        chk("e_no_ins", 32'(ins), 0);
        chk("e_dist", 32'(dut.r_dist), 4);
        chk("e_idle", 32'(busy), 0);

        // frames 2..50 at speed 4: exactly one spawn, on frame 50
        spawns      = 0;
        spawn_frame = 0;
        bad_done    = 0;
        sp_d        = '0;
        for (int f = 2; f <= 50; f++) begin
            run_pass(4'd4, 0, d_at, ins, ins_d);
            if (d_at != 3) bad_done++;
            if (ins) begin
                spawns++;
                spawn_frame = f;
                sp_d        = ins_d;
            end
        end
        chk("sp_count", 32'(spawns), 1);
        chk("sp_frame", 32'(spawn_frame), 50);
        chk("sp_x", 32'(int'(sp_d.x)), 640);
        chk("sp_gap", 32'(sp_d.gap_y), 161);
        chk("sp_dist", 32'(dut.r_dist), 0);
        chk("sp_lfsr", 32'(dut.w_lfsr), 32'h59C3);
        chk("sp_done_lat", 32'(bad_done), 0);

        // scroll and write-back
        lif.count = 5'd2;
        ex_in[0]  = '{x: 11'sd100, gap_y: 9'd5};
        ex_in[1]  = '{x: 11'sd300, gap_y: 9'd7};
        run_pass(4'd3, 2, d_at, ins, ins_d);
        chk("wb0_x", 32'(int'(wb[0].x)), 97);
        chk("wb1_x", 32'(int'(wb[1].x)), 297);
        chk("wb0_gap", 32'(wb[0].gap_y), 5);
        chk("wb1_gap", 32'(wb[1].gap_y), 7);
        chk("wb_rm0", 32'(rm[0]), 0);
        chk("wb_rm1", 32'(rm[1]), 0);
        chk("wb_done_at", 32'(d_at), 5);

        // removal boundary
        ex_in[0] = '{x: -11'sd49, gap_y: 9'd9};
        ex_in[1] = '{x: -11'sd48, gap_y: 9'd9};
        run_pass(4'd3, 2, d_at, ins, ins_d);
        chk("rm_m49", 32'(rm[0]), 1);
        chk("rm_m48", 32'(rm[1]), 0);
        chk("rm_m48_x", 32'(int'(wb[1].x)), 32'(-51));
        chk("rm_dist", 32'(dut.r_dist), 6);

        // full list with spawn due: 14 frames at 15 -> dist 216
        lif.count = 5'd16;
        spawns    = 0;
        bad_done  = 0;
        for (int f = 0; f < 14; f++) begin
            run_pass(4'd15, 0, d_at, ins, ins_d);
            if (ins) spawns++;
            if (d_at != 3) bad_done++;
        end
        chk("full_no_ins", 32'(spawns), 0);
        chk("full_done", 32'(bad_done), 0);
        chk("full_dist", 32'(dut.r_dist), 216);
        chk("full_lfsr", 32'(dut.w_lfsr), 32'h59C3);

        // room again: spawn keeps remainder, second LFSR value
        lif.count = 5'd2;
        run_pass(4'd0, 0, d_at, ins, ins_d);
        chk("sp2_ins", 32'(ins), 1);
        chk("sp2_gap", 32'(ins_d.gap_y), 131);
        chk("sp2_dist", 32'(dut.r_dist), 16);
        chk("sp2_lfsr", 32'(dut.w_lfsr), 32'hB387);

        // ce low freezes START
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        speed       = 4'd1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        ce          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ce_hold_start", 32'(lif.iter_start), 1);
        @(posedge clk);
        #1;
        ce = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("ce_done", 32'(done), 1);
        chk("ce_dist", 32'(dut.r_dist), 17);

        // overrun during ITER, then reset mid-pass
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        speed       = 4'd2;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        lif.iter_done = 1'b0;
        lif.iter_out  = '{x: 11'sd100, gap_y: 9'd3};
        frame_start   = 1'b1;
        speed         = 4'd9;
        @(negedge clk);
        chk("ovr_missed", 32'(frame_missed), 1);
        chk("ovr_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        chk("ovr_dist", 32'(dut.r_dist), 19);
        chk("ovr_spd", 32'(dut.r_spd_q), 2);
        chk("ovr_iin_x", 32'(int'(lif.iter_in.x)), 98);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_rm", 32'(lif.iter_remove), 0);
        chk("mrst_iin", 32'(lif.iter_in), 0);
        chk("mrst_ins", 32'(lif.insert_en), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_dist", 32'(dut.r_dist), 0);
        lif.iter_done = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipes_updater.md
# pipes_updater

Per-frame scroller and spawner for the pipe obstacle list. On each frame tick it drives one full iteration pass over `pipes_list`, moves every pipe left by the current scroll speed, drops pipes that have fully left the screen, and then inserts a new pipe when enough distance has scrolled since the last spawn. It is the client end of the list's iterate/insert interface and sits between the game-tick logic and `pipes_list`.

## Interface

Clock is `clk`; reset is `rst`, synchronous and active-high.

**Parameters**

- `SCREEN_WIDTH`, default 640: x coordinate given to a newly spawned pipe.
- `PIPE_WIDTH`, default 52: pipe width in pixels; used by the removal test.
- `SPAWN_INTERVAL`, default 200: scrolled pixels between spawns.
- `MAX_PIPES`, default 16: spawn is suppressed when `count >= MAX_PIPES`.
- `GAP_MIN`, default 64: minimum `gap_y`.
- `GAP_RANGE_LOG2`, default 7: random `gap_y` span is 2^N.

**Ports**

- `clk` in, 1: clock.
- `rst` in, 1: synchronous active-high reset.
- `ce` in, 1: clock enable. It is shared with `pipes_list`; all registers hold while it is low.
- `frame_start` in, 1: one-cycle pulse that requests an update pass.
- `speed` in, 4: pixels per frame, sampled on an accepted `frame_start`.
- `busy` out, 1: high from acceptance until `done`.
- `done` out, 1: one-cycle pulse at the end of a pass.
- `frame_missed` out, 1: one-cycle pulse when `frame_start` arrives while `busy`.
- `count` in, 5: element count from the list.
- `iter_start` out, 1: starts list iteration.
- `iter_done` in, 1: list iteration finished or idle.
- `iter_out` in, `pipe_t`: current element.
- `iter_in` out, `pipe_t`: updated element written back.
- `iter_remove` out, 1: drop the current element.
- `insert_en` out, 1: append `insert_data`.
- `insert_data` out, `pipe_t`: new pipe.

## Operation

- `pipe_t` has two fields: `x`, signed 11 bits, the left edge; `gap_y`, unsigned 9 bits.
- The FSM has four states: IDLE, START, ITER, SPAWN.
- **IDLE:**
  - On `frame_start`, latch `speed` into `spd_q`, add `spd_q` to the distance accumulator `dist` (10 bits, saturating at 1023), and go to START.
- **START:**
  - Assert `iter_start` for exactly one cycle, then go to ITER.
- **ITER:**
  - While `iter_done`=0, the step is combinational on `iter_out`:
    - `nx = iter_out.x - spd_q`, computed in 12-bit signed arithmetic.
    - `iter_remove = (nx + PIPE_WIDTH <= 0)`.
    - `iter_in = {x: nx[10:0], gap_y: iter_out.gap_y}`.
  - When `iter_done`=1, go to SPAWN. This also covers an empty list, where `iter_done` never drops.
- **SPAWN:**
  - If `dist >= SPAWN_INTERVAL` and `count < MAX_PIPES`:
    - assert `insert_en` for one cycle;
    - `insert_data = {SCREEN_WIDTH, GAP_MIN + lfsr[GAP_RANGE_LOG2-1:0]}`;
    - `dist -= SPAWN_INTERVAL`, so the remainder is kept;
    - step the LFSR once.
  - In either case, pulse `done` and return to IDLE.
- `insert_en` is never asserted while `iter_done`=0, because the list shares its write port between insert and write-back.
- `iter_in` and `iter_remove` are driven to 0 outside ITER.
- A `frame_start` arriving while `busy` is dropped and `frame_missed` pulses; `dist` and `spd_q` are unchanged.
- The LFSR is 16-bit Fibonacci with taps 16,14,13,11 and seed 16'hACE1. It steps only on a spawn.

## Timing

- Reset values:
  - state IDLE; `busy`, `done`, `frame_missed`, `iter_start`, `insert_en`, `iter_remove` all 0;
  - `iter_in` and `insert_data` are 0;
  - `dist` = 0, `spd_q` = 0, LFSR = 16'hACE1.
- `frame_start` in cycle T gives START in T+1, with `iter_start` high, and ITER from T+2.
- The list lowers `iter_done` in T+2 when it is non-empty. One element is processed per cycle while `iter_done`=0.
- For N elements, `done` pulses in cycle T+N+3 (T+3 when the list is empty). `busy` is high from T+1 through the `done` cycle inclusive.
- `ce`=0 freezes the FSM, `dist`, and the LFSR. Combinational outputs still follow state.
- `rst` mid-pass returns to IDLE on the next edge. `pipes_list` shares `rst`, so no half-finished pass survives.
- If `frame_start` arrives in the `done` cycle, it is treated as busy (missed).

## Structure

- A shared package/header `pipe_t.sv` holds:
  - the `pipe_t` typedef;
  - the `SCREEN_WIDTH` and `PIPE_WIDTH` defaults, which are shared with the renderer and collision logic.
- Sub-module `lfsr16`: ports `clk`, `rst`, `ce`, `step`, `value[15:0]`; seed parameter.
- The FSM, accumulator, and step datapath live in `pipes_updater`.

## Test plan

- **Empty list, `speed`=4, one `frame_start`:**
  - `iter_start` at T+1, `done` at T+3;
  - `dist`=4, so no insert.
- **Spawn threshold:** 50 frames at `speed`=4.
  - The 50th frame inserts `{x=640, gap_y=64+(16'hACE1 & 127)=64+97=161}` with `dist` returning to 0.
  - Exactly one spawn occurs over those frames.
- **Scroll and write-back:** list holds `{x=100}` and `{x=300}`, `speed`=3.
  - Write-back values are 97 and 297.
  - No remove; `done` at T+5.
- **Removal boundary:** `x=-49`, `speed`=3.
  - `nx=-52` gives `nx + PIPE_WIDTH = 0`, so `iter_remove`=1.
  - `x=-48` gives `iter_remove`=0 with `iter_in.x=-51`.
- **Full list, spawn due:** `count`=16, `dist` ≥ 200.
  - No `insert_en`, LFSR unchanged, `done` still pulses.
- **Overrun and reset:**
  - `frame_start` during ITER pulses `frame_missed` and leaves `dist` unchanged.
  - `rst` in ITER gives IDLE next cycle with all outputs 0.
